// File: rtl/quad_emu_pkg.sv
// Shared types and constants for the quadrature encoder emulator.
package quad_emu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  // Packed {p3,p2,p1,p0}: phase index p selects {A,B} = 00,10,11,01.
  localparam logic [7:0] PHASE_AB_LUT = {2'b01, 2'b11, 2'b10, 2'b00};

  function automatic logic [1:0] phase_to_ab(input logic [1:0] p);
    return PHASE_AB_LUT[{p, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/quad_edge_timer.sv
// Terminal-count timer: tick_o fires on the enabled cycle whose count reaches limit_i,
// then the count restarts. clr_i holds the count at zero.
module quad_edge_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] limit_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] cnt_plus_s;
  logic             term_s;

  assign cnt_plus_s = cnt_q + DIV_W'(1);
  assign term_s     = (cnt_plus_s == limit_i);
  assign tick_o     = en_i && term_s;

  // Next count: clear wins, otherwise advance and wrap on terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {DIV_W{1'b0}};
    end else if (en_i) begin
      cnt_d = term_s ? {DIV_W{1'b0}} : cnt_plus_s;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {DIV_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/quadrature_encoder_emulator.sv
// Quadrature A/B generator driven by step/direction/half-period commands.
// Optional contact-bounce glitching is compiled in with QUAD_EMU_BOUNCE_EN.
module quadrature_encoder_emulator
  import quad_emu_pkg::*;
#(
  parameter int STEP_W        = 16,
  parameter int DIV_W         = 16,
  parameter int POS_W         = 32,
  parameter int BOUNCE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    dir,
  input  logic [STEP_W-1:0]       steps,
  input  logic [DIV_W-1:0]        half_period,
  input  logic                    abort,
  output logic                    A,
  output logic                    B,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] position
);

  state_e              state_q, state_d;
  logic                dir_q, dir_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic [DIV_W-1:0]    hp_q, hp_d;
  logic [1:0]          phase_q, phase_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [1:0]          ab_q, ab_d;
  logic                busy_q, done_q;
  logic                timer_clr_s, timer_en_s, tick_s;
  logic [1:0]          level_s;

  // Timer only runs in RUN; abort suppresses any edge due on the same cycle.
  assign timer_clr_s = (state_q != ST_RUN);
  assign timer_en_s  = (state_q == ST_RUN) && !abort;

  quad_edge_timer #(.DIV_W(DIV_W)) u_timer (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (timer_clr_s),
    .en_i    (timer_en_s),
    .limit_i (hp_q),
    .tick_o  (tick_s)
  );

  // Command FSM, phase stepping and position bookkeeping.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    hp_d    = hp_q;
    phase_d = phase_q;
    pos_d   = pos_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          dir_d   = dir;
          rem_d   = steps;
          hp_d    = (half_period == {DIV_W{1'b0}}) ? DIV_W'(1) : half_period;
          state_d = (steps == {STEP_W{1'b0}}) ? ST_DONE : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tick_s) begin
          phase_d = (dir_q == DIR_CCW) ? (phase_q - 2'd1) : (phase_q + 2'd1);
          pos_d   = (dir_q == DIR_CW) ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
          rem_d   = rem_q - STEP_W'(1);
          state_d = (rem_q == STEP_W'(1)) ? ST_DONE : ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign level_s = phase_to_ab(phase_d);

`ifdef QUAD_EMU_BOUNCE_EN
  localparam int BCNT_W = (BOUNCE_CYCLES < 1) ? 1 : $clog2(BOUNCE_CYCLES + 1);

  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [1:0]        mask_q, mask_d;

  // Invert the channel that just moved for BOUNCE_CYCLES cycles, starting one cycle after the edge.
  always_comb begin
    ab_d   = level_s;
    bcnt_d = bcnt_q;
    mask_d = mask_q;
    if (tick_s) begin
      bcnt_d = (hp_q > DIV_W'(BOUNCE_CYCLES + 1)) ? BCNT_W'(BOUNCE_CYCLES) : {BCNT_W{1'b0}};
      mask_d = phase_to_ab(phase_q) ^ level_s;
    end else if (bcnt_q != {BCNT_W{1'b0}}) begin
      bcnt_d = bcnt_q - BCNT_W'(1);
      ab_d   = level_s ^ mask_q;
    end else begin
      ab_d = level_s;
    end
  end

  // Bounce bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt_q <= {BCNT_W{1'b0}};
      mask_q <= 2'b00;
    end else begin
      bcnt_q <= bcnt_d;
      mask_q <= mask_d;
    end
  end
`else
  assign ab_d = level_s;
`endif

  // State and output registers; busy/done follow the state one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_CW;
      rem_q   <= {STEP_W{1'b0}};
      hp_q    <= DIV_W'(1);
      phase_q <= 2'b00;
      pos_q   <= {POS_W{1'b0}};
      ab_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      hp_q    <= hp_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      ab_q    <= ab_d;
      busy_q  <= (state_q == ST_RUN);
      done_q  <= (state_q == ST_DONE);
    end
  end

  assign A        = ab_q[1];
  assign B        = ab_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign position = pos_q;

endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// Self-checking bench: per-cycle comparison of A/B, busy, done and position
// against an arithmetic model of edge count versus elapsed cycles.
module tb_quadrature_encoder_emulator;

  localparam int STEP_W = 16;
  localparam int DIV_W  = 16;
  localparam int POS_W  = 32;
  localparam int BNC    = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start;
  logic                    dir;
  logic [STEP_W-1:0]       steps;
  logic [DIV_W-1:0]        half_period;
  logic                    abort;
  logic                    A, B, busy, done;
  logic signed [POS_W-1:0] position;

  int     errors = 0;
  int     checks = 0;
  int     ph_m   = 0;
  longint pos_m  = 0;
  logic [1:0] ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  quadrature_encoder_emulator #(
    .STEP_W(STEP_W), .DIV_W(DIV_W), .POS_W(POS_W), .BOUNCE_CYCLES(BNC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .steps(steps),
    .half_period(half_period), .abort(abort), .A(A), .B(B), .busy(busy),
    .done(done), .position(position)
  );

  always #10 clk = ~clk;

  function automatic int m4(input int x);
    return ((x % 4) + 4) % 4;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and check every cycle; abort_at/poke_at are cycles after accept (0 = none).
  task automatic run_cmd(input logic d, input int n, input int hp, input int abort_at, input int poke_at);
    int hpe, sgn, kk, ek, idx, e, last_k;
    bit aborted;
    logic [1:0] ab_e;
    longint p_e;
    hpe     = (hp == 0) ? 1 : hp;
    sgn     = d ? -1 : 1;
    aborted = (abort_at > 0) && (n > 0);
    last_k  = aborted ? (abort_at + hpe + 3) : (n * hpe + 4);
    ek      = 0;
    @(negedge clk);
    start = 1'b1; dir = d; steps = STEP_W'(n); half_period = DIV_W'(hp); abort = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = (poke_at == 1);
    abort = (abort_at == 1);
    if (poke_at == 1) begin dir = ~d; steps = STEP_W'(3); half_period = DIV_W'(1); end
    for (int k = 1; k <= last_k; k++) begin
      @(posedge clk);
      @(negedge clk);
      kk = aborted ? ((k < abort_at - 1) ? k : abort_at - 1) : k;
      ek = kk / hpe;
      if (ek > n) ek = n;
      idx  = m4(ph_m + sgn * ek);
      ab_e = ab_tab[idx];
`ifdef QUAD_EMU_BOUNCE_EN
      if (ek > 0 && hpe > BNC + 1) begin
        e = ek * hpe;
        if (k - e >= 1 && k - e <= BNC) ab_e = ab_e ^ (ab_tab[idx] ^ ab_tab[m4(idx - sgn)]);
      end
`else
      e = 0;
`endif
      p_e = pos_m + sgn * ek;
      chk("ab", {62'd0, A, B}, {62'd0, ab_e});
      chk("busy", {63'd0, busy},
          {63'd0, aborted ? (k <= abort_at) : (n > 0 && k <= n * hpe)});
      chk("done", {63'd0, done}, {63'd0, (!aborted && k == n * hpe + 1)});
      chk("position", {32'd0, $unsigned(position)}, {32'd0, p_e[31:0]});
      start = (k + 1 == poke_at);
      abort = (k + 1 == abort_at);
      if (k + 1 == poke_at) begin dir = ~d; steps = STEP_W'(3); half_period = DIV_W'(1); end
    end
    start = 1'b0; abort = 1'b0;
    ph_m  = m4(ph_m + sgn * ek);
    pos_m = pos_m + sgn * ek;
  endtask

  initial begin
    int n, hp, hpe, ab_at;
    logic d;
    reset = 1'b0; start = 1'b0; dir = 1'b0; abort = 1'b0;
    steps = '0; half_period = '0;
    repeat (3) @(negedge clk);
    chk("rst_ab", {62'd0, A, B}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_pos", {32'd0, $unsigned(position)}, 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_cmd(1'b0, 8, 3, 0, 2);   // CW, busy-time start ignored
    run_cmd(1'b1, 4, 1, 0, 0);   // CCW, edge every cycle
    run_cmd(1'b0, 6, 5, 12, 0);  // abort after two edges
    run_cmd(1'b0, 0, 2, 0, 0);   // zero steps
    run_cmd(1'b1, 3, 0, 0, 0);   // half_period 0 behaves as 1

    // start together with abort is ignored
    @(negedge clk);
    start = 1'b1; abort = 1'b1; dir = 1'b0; steps = STEP_W'(5); half_period = DIV_W'(1);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("sa_busy", {63'd0, busy}, 64'd0);
      chk("sa_done", {63'd0, done}, 64'd0);
      chk("sa_ab", {62'd0, A, B}, {62'd0, ab_tab[ph_m]});
    end

    // reset mid-RUN after three edges
    @(negedge clk);
    start = 1'b1; dir = 1'b0; steps = STEP_W'(8); half_period = DIV_W'(2);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) begin @(posedge clk); @(negedge clk); end
    chk("mid_pos", {32'd0, $unsigned(position)}, {32'd0, 32'(pos_m + 3)});
    chk("mid_busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    chk("arst_ab", {62'd0, A, B}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_pos", {32'd0, $unsigned(position)}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    ph_m = 0; pos_m = 0;
    @(posedge clk);
    run_cmd(1'b0, 4, 2, 0, 0);

    // randomized commands, some aborted
    for (int r = 0; r < 10; r++) begin
      d   = 1'($urandom % 2);
      n   = int'($urandom_range(0, 7));
      hp  = int'($urandom_range(0, 4));
      hpe = (hp == 0) ? 1 : hp;
      ab_at = 0;
      if (($urandom % 3) == 0 && n * hpe >= 2) ab_at = int'($urandom_range(2, n * hpe));
      run_cmd(d, n, hp, ab_at, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
